// File: rtl/i2c_report_pkg.sv
// Shared types and constants for the I2C report controller.
// Status byte layout: {new_data, overrun, 1'b0, seq[4:0]}.
package i2c_report_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        COMMIT
    } lock_state_e;

    localparam int unsigned ST_NEW         = 7;
    localparam int unsigned ST_OVR         = 6;
    localparam int unsigned ST_SEQ_MSB     = 4;
    localparam int unsigned BYTES_PER_READ = 3;

    function automatic logic [7:0] pack_status(input logic       new_data,
                                               input logic       overrun,
                                               input logic [4:0] seq);
        logic [7:0] s;
        s                 = '0;
        s[ST_NEW]         = new_data;
        s[ST_OVR]         = overrun;
        s[ST_SEQ_MSB:0]   = seq;
        return s;
    endfunction

endpackage

// File: rtl/i2c_lock_timer.sv
// Up-counter bounding how long a read may hold the snapshot lock.
// clr reloads zero; expire pulses on the counting cycle that reaches LIMIT-1.
module i2c_lock_timer #(
    parameter int unsigned LIMIT = 100000,
    localparam int unsigned W    = $clog2(LIMIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/i2c_report_ctrl.sv
// Live/pending/snapshot register set feeding a 3-byte read-only I2C slave.
// The snapshot is frozen while a read is in flight; updates arriving meanwhile are committed after.
module i2c_report_ctrl
    import i2c_report_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SEQ_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd_valid,
    input  logic [7:0] upd_x,
    input  logic [7:0] upd_y,
    input  logic       i2c_start,
    input  logic       i2c_byte_done,
    input  logic       i2c_stop,
    output logic [7:0] snap_x,
    output logic [7:0] snap_y,
    output logic [7:0] snap_status,
    output logic       data_rdy,
    output logic       locked
);

    lock_state_e      state_q;
    logic [7:0]       live_x_q, live_y_q, pend_x_q, pend_y_q;
    logic [SEQ_W-1:0] seq_q, pend_cnt_q;
    logic             new_data_q, overrun_q, pend_valid_q;
    logic [1:0]       byte_cnt_q;
    logic [7:0]       snap_x_q, snap_y_q, snap_status_q;

    logic             in_lock, start_idle, restart;
    logic             take_live, take_pend, status_done, expire, commit_go;
    logic [7:0]       pend_x_d, pend_y_d;
    logic [SEQ_W-1:0] pend_cnt_d;
    logic             pend_valid_d;

    assign in_lock     = (state_q == LOCKED);
    assign start_idle  = (state_q == UNLOCKED) && i2c_start;
    assign restart     = in_lock && i2c_start;
    assign take_live   = upd_valid && (((state_q == UNLOCKED) && !i2c_start) ||
                                       (state_q == COMMIT));
    assign take_pend   = upd_valid && (start_idle || in_lock);
    assign status_done = in_lock && !i2c_start && i2c_byte_done &&
                         (byte_cnt_q == 2'(BYTES_PER_READ - 1));
    assign commit_go   = in_lock && !i2c_start && (i2c_stop || expire);

    i2c_lock_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_lock_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_lock || i2c_start),
        .en     (in_lock && !i2c_start),
        .expire (expire)
    );

    // Pending view including this cycle's update, so a stop can commit it on the same edge.
    always_comb begin
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_cnt_d   = pend_cnt_q;
        pend_valid_d = pend_valid_q;
        if (take_pend) begin
            pend_x_d     = upd_x;
            pend_y_d     = upd_y;
            pend_cnt_d   = pend_cnt_q + SEQ_W'(1);
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= UNLOCKED;
            live_x_q      <= '0;
            live_y_q      <= '0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            seq_q         <= '0;
            pend_cnt_q    <= '0;
            new_data_q    <= 1'b0;
            overrun_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            byte_cnt_q    <= '0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_status_q <= '0;
        end else begin
            if (!in_lock) begin
                snap_x_q      <= live_x_q;
                snap_y_q      <= live_y_q;
                snap_status_q <= pack_status(new_data_q, overrun_q, seq_q);
            end

            // Later assignments win: the byte-3 flag clear is applied before any new flag set.
            if (status_done) begin
                new_data_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (take_pend && pend_valid_q) overrun_q <= 1'b1;
            if (expire) overrun_q <= 1'b1;

            if (take_live) begin
                live_x_q   <= upd_x;
                live_y_q   <= upd_y;
                seq_q      <= seq_q + SEQ_W'(1);
                new_data_q <= 1'b1;
            end

            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_cnt_q   <= pend_cnt_d;
            pend_valid_q <= pend_valid_d;
            if (commit_go) begin
                if (pend_valid_d) begin
                    live_x_q   <= pend_x_d;
                    live_y_q   <= pend_y_d;
                    seq_q      <= seq_q + pend_cnt_d;
                    new_data_q <= 1'b1;
                end
                pend_cnt_q   <= '0;
                pend_valid_q <= 1'b0;
            end

            if (start_idle || restart) begin
                byte_cnt_q <= '0;
            end else if (in_lock && i2c_byte_done && byte_cnt_q != 2'(BYTES_PER_READ)) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end

            unique case (state_q)
                UNLOCKED: if (i2c_start) state_q <= LOCKED;
                LOCKED:   if (commit_go) state_q <= COMMIT;
                COMMIT:   state_q <= UNLOCKED;
                default:  state_q <= UNLOCKED;
            endcase
        end
    end

    assign snap_x      = snap_x_q;
    assign snap_y      = snap_y_q;
    assign snap_status = snap_status_q;
    assign data_rdy    = new_data_q;
    assign locked      = (state_q != UNLOCKED);

endmodule

// File: tb/tb_i2c_report_ctrl.sv
// Scoreboard bench: a transaction-level model predicts the outputs after every edge,
// a negedge monitor pops and compares; directed checks cover the documented scenarios.
module tb_i2c_report_ctrl;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       upd_valid = 1'b0;
    logic [7:0] upd_x = '0, upd_y = '0;
    logic       i2c_start = 1'b0, i2c_byte_done = 1'b0, i2c_stop = 1'b0;
    logic [7:0] snap_x, snap_y, snap_status;
    logic       data_rdy, locked;

    always #5 clk = ~clk;

    i2c_report_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .SEQ_W          (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .upd_valid     (upd_valid),
        .upd_x         (upd_x),
        .upd_y         (upd_y),
        .i2c_start     (i2c_start),
        .i2c_byte_done (i2c_byte_done),
        .i2c_stop      (i2c_stop),
        .snap_x        (snap_x),
        .snap_y        (snap_y),
        .snap_status   (snap_status),
        .data_rdy      (data_rdy),
        .locked        (locked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {logic [7:0] x; logic [7:0] y;} xy_t;
    typedef struct packed {logic [7:0] sx; logic [7:0] sy; logic [7:0] ss; logic rdy; logic lk;} obs_t;

    // Reference model: live sample, list of updates queued during a read, read progress.
    xy_t        pend_q[$];
    obs_t       exp_q[$];
    logic [7:0] m_x, m_y, e_sx, e_sy, e_ss;
    bit         m_new, m_ovr;
    int         m_seq, m_mode, m_bytes, m_elapsed;  // m_mode: 0 idle, 1 reading, 2 committing

    function automatic logic [7:0] m_status();
        logic [4:0] s;
        s = 5'(m_seq % 32);
        return {m_new, m_ovr, 1'b0, s};
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m_x = 0; m_y = 0; m_new = 0; m_ovr = 0; m_seq = 0; m_mode = 0;
        m_bytes = 0; m_elapsed = 0; e_sx = 0; e_sy = 0; e_ss = 0;
    endtask

    task automatic live_write(input logic [7:0] ux, input logic [7:0] uy);
        m_x = ux; m_y = uy; m_seq++; m_new = 1;
    endtask

    task automatic model_step(input bit uv, input logic [7:0] ux, input logic [7:0] uy,
                              input bit st, input bit bd, input bit sp);
        bit tmo;
        tmo = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_mode != 1) begin
            e_sx = m_x; e_sy = m_y; e_ss = m_status();
        end
        case (m_mode)
            0: begin
                if (st) begin
                    m_mode = 1; m_bytes = 0; m_elapsed = 0;
                    if (uv) pend_q.push_back({ux, uy});
                end else if (uv) begin
                    live_write(ux, uy);
                end
            end
            1: begin
                if (st) begin
                    m_bytes = 0; m_elapsed = 0;
                end else begin
                    tmo = (m_elapsed == TO - 1);
                    m_elapsed++;
                    if (bd && m_bytes < 3) begin
                        m_bytes++;
                        if (m_bytes == 3) begin m_new = 0; m_ovr = 0; end
                    end
                end
                if (uv) begin
                    pend_q.push_back({ux, uy});
                    if (pend_q.size() > 1) m_ovr = 1;
                end
                if (tmo) m_ovr = 1;
                if (tmo || (sp && !st)) begin
                    if (pend_q.size() > 0) begin
                        {m_x, m_y} = pend_q[$];
                        m_seq += pend_q.size();
                        m_new = 1;
                    end
                    pend_q.delete();
                    m_mode = 2;
                end
            end
            default: begin
                if (uv) live_write(ux, uy);
                m_mode = 0;
            end
        endcase
    endtask

    task automatic cyc(input bit uv, input logic [7:0] ux, input logic [7:0] uy,
                       input bit st, input bit bd, input bit sp);
        obs_t e;
        upd_valid = uv; upd_x = ux; upd_y = uy;
        i2c_start = st; i2c_byte_done = bd; i2c_stop = sp;
        @(posedge clk);
        model_step(uv, ux, uy, st, bd, sp);
        e = {e_sx, e_sy, e_ss, m_new, (m_mode != 0)};
        exp_q.push_back(e);
        #1;
        upd_valid = 0; i2c_start = 0; i2c_byte_done = 0; i2c_stop = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 8'h00, 8'h00, 0, 0, 0);
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 0;
        idle(2);
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {snap_x, snap_y, snap_status, data_rdy, locked};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL scoreboard @%0t: got x=%h y=%h st=%h rdy=%b lk=%b, expected x=%h y=%h st=%h rdy=%b lk=%b",
                         $time, a.sx, a.sy, a.ss, a.rdy, a.lk, e.sx, e.sy, e.ss, e.rdy, e.lk);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        bit use_stop;
        model_reset();
        do_reset();
        check8("reset_status", snap_status, 8'h00);
        check8("reset_flags", {6'd0, data_rdy, locked}, 8'h00);

        // Update visible two cycles later.
        cyc(1, 8'h12, 8'h34, 0, 0, 0);
        idle(1);
        check8("t1_x", snap_x, 8'h12);
        check8("t1_y", snap_y, 8'h34);
        check8("t1_status", snap_status, 8'h81);
        check8("t1_rdy", {7'd0, data_rdy}, 8'h01);

        // Frozen snapshot during a read, pending update committed after stop.
        cyc(0, 8'h00, 8'h00, 1, 0, 0);
        cyc(1, 8'h55, 8'h66, 0, 0, 0);
        check8("t2_frozen_x", snap_x, 8'h12);
        check8("t2_locked", {7'd0, locked}, 8'h01);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 8'h00, 0, 1, 0);
        check8("t2_frozen_status", snap_status, 8'h81);
        check8("t2_rdy_cleared", {7'd0, data_rdy}, 8'h00);
        cyc(0, 8'h00, 8'h00, 0, 0, 1);
        idle(1);
        check8("t2_commit_x", snap_x, 8'h55);
        check8("t2_commit_y", snap_y, 8'h66);
        check8("t2_commit_status", snap_status, 8'h82);
        check8("t2_unlocked", {7'd0, locked}, 8'h00);

        // Two pending updates: last wins, overrun set, seq advances by two.
        do_reset();
        cyc(1, 8'h10, 8'h20, 0, 0, 0);
        idle(2);
        cyc(0, 8'h00, 8'h00, 1, 0, 0);
        cyc(1, 8'h01, 8'h02, 0, 0, 0);
        cyc(1, 8'h03, 8'h04, 0, 0, 0);
        cyc(0, 8'h00, 8'h00, 0, 0, 1);
        idle(1);
        check8("t3_x", snap_x, 8'h03);
        check8("t3_y", snap_y, 8'h04);
        check8("t3_status", snap_status, 8'hC3);

        // Stalled read: forced unlock after TO+1 cycles with sticky overrun.
        cyc(0, 8'h00, 8'h00, 1, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            cyc(0, 8'h00, 8'h00, 0, (i <= 3), 0);
            if (i == 16) check8("t4_still_locked", {7'd0, locked}, 8'h01);
        end
        check8("t4_unlocked", {7'd0, locked}, 8'h00);
        check8("t4_status", snap_status, 8'h43);

        // Sequence counter wrap.
        do_reset();
        for (int i = 1; i <= 32; i++) cyc(1, 8'(i), 8'(~i), 0, 0, 0);
        idle(1);
        check8("t5_wrap", snap_status, 8'h80);
        cyc(1, 8'hA0, 8'hB0, 0, 0, 0);
        idle(1);
        check8("t5_after_wrap", snap_status, 8'h81);

        // Update coincident with start goes to pending.
        cyc(1, 8'h77, 8'h88, 1, 0, 0);
        idle(1);
        check8("t6_held_x", snap_x, 8'hA0);
        cyc(0, 8'h00, 8'h00, 0, 0, 1);
        idle(1);
        check8("t6_commit_x", snap_x, 8'h77);
        check8("t6_commit_y", snap_y, 8'h88);
        check8("t6_commit_status", snap_status, 8'h82);

        // Reset in the middle of a read clears everything at once.
        cyc(0, 8'h00, 8'h00, 1, 0, 0);
        cyc(1, 8'h11, 8'h22, 0, 1, 0);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check8("t6_rst_x", snap_x, 8'h00);
        check8("t6_rst_status", snap_status, 8'h00);
        check8("t6_rst_flags", {6'd0, data_rdy, locked}, 8'h00);
        idle(2);
        rst_n = 1;

        // Randomized reads with updates, byte counts, repeated starts, stops and timeouts.
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 3)) cyc(($urandom % 2) == 0, 8'($urandom), 8'($urandom), 0, 0, 0);
            cyc(($urandom % 4) == 0, 8'($urandom), 8'($urandom), 1, 0, 0);
            len = $urandom_range(1, 20);
            use_stop = ($urandom % 4) != 0;
            for (int i = 0; i < len; i++) begin
                cyc(($urandom % 3) == 0, 8'($urandom), 8'($urandom), ($urandom % 25) == 0,
                    ($urandom % 3) == 0, use_stop && (i == len - 1));
            end
            cyc(($urandom % 2) == 0, 8'($urandom), 8'($urandom), 0, 0, 0);
        end

        idle(3);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
